operand_collector_8: RTL and testbench
======================================

OPERAND_COLLECTOR_8 -- requirements
Module: operand_collector_8

Interface
REQ-001 SHALL have parameter p_width, default 6, meaning half the operand width; each operand is 2*p_width bits.
REQ-002 SHALL have port i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_valid  input  1  upstream operand valid.
REQ-005 SHALL have port o_ready  output  1  block accepts an operand this cycle.
REQ-006 SHALL have port i_data  input  2*p_width  operand value, unsigned.
REQ-007 SHALL have port i_last  input  1  marks the final operand of a short group; qualified by i_valid.
REQ-008 SHALL have port o_valid  output  1  collected group available downstream.
REQ-009 SHALL have port i_ready  input  1  downstream consumes the group.
REQ-010 SHALL have port o_ops  output  16*p_width  eight operand slots; slot 0 at LSBs, slot 7 at MSBs.
REQ-011 SHALL have port o_cnt  output  4  number of operands captured in the group, 1..8.
REQ-012 SHALL have port o_sum  output  2*p_width+3  unsigned sum of all eight slots.

Function
REQ-013 SHALL implement a two-state FSM: COLLECT and HOLD.
REQ-014 In COLLECT, o_ready SHALL be 1 and o_valid 0; in HOLD, o_ready SHALL be 0 and o_valid 1.
REQ-015 A transfer SHALL occur when i_valid and o_ready are both 1; i_data is written to slot idx, and idx increments.
REQ-016 On a transfer with idx==7 or i_last==1, the FSM SHALL enter HOLD next cycle; o_cnt = idx+1 for that transfer.
REQ-017 Unfilled slots of a short group SHALL read zero, so o_sum covers only the received operands.
REQ-018 o_valid SHALL assert in the cycle after the closing transfer (latency 1 cycle).
REQ-019 In HOLD, o_ops, o_cnt and o_sum SHALL stay stable until i_ready==1.
REQ-020 On i_ready==1 in HOLD:
- all slots SHALL clear to zero;
- idx SHALL return to 0;
- the FSM SHALL return to COLLECT next cycle.
REQ-021 There SHALL be no bypass: an upstream operand offered during HOLD is not accepted, so peak throughput is 8 operands per 9 cycles.
REQ-022 i_data and i_last SHALL be ignored when i_valid==0; i_ready SHALL be ignored in COLLECT.
REQ-023 o_sum SHALL be full-precision, with no overflow possible; maximum 8*(2^(2*p_width)-1).
REQ-024 o_sum SHALL derive from registered slots only, with no combinational path from i_data.

Reset
REQ-025 On i_rst==1 at a clock edge, the block SHALL set:
- FSM to COLLECT;
- idx 0 and all slots 0;
- o_valid 0, o_cnt 0, o_sum 0.
REQ-026 o_ready SHALL be 0 while i_rst is 1 and 1 in the first cycle after release.
REQ-027 Reset mid-group or during HOLD SHALL discard the partial or held group, and no o_valid SHALL follow for it.

Structure
REQ-028 Operand width, slot count (8) and the FSM state encoding SHALL live in a shared package.
REQ-029 o_sum SHALL come from one instance of the existing adder_8in (p_width passed through), fed by slots 0..7 as i_a..i_h.
REQ-030 The FSM, index counter and slot registers SHALL be the only logic in the top module.

Verification
REQ-031 The bench SHALL send 8 x 0x03f back-to-back, then expect o_valid one cycle after the 8th accept with o_sum=0x1F8 and o_cnt=8.
REQ-032 The bench SHALL send 0x03f followed by 7 x 0x00f, then expect o_sum=0x0A8 and o_cnt=8.
REQ-033 The bench SHALL send 0x001, 0x002, 0x003 with i_last on the third, then expect:
- o_cnt=3 and o_sum=0x006;
- slots 3..7 equal to zero.
REQ-034 The bench SHALL hold i_ready=0 for 5 cycles in HOLD with i_valid=1 and expect:
- o_ready=0;
- outputs stable;
- no operand consumed;
- group accepted on the cycle i_ready rises.
REQ-035 The bench SHALL assert i_rst after 4 accepts, then send 8 x 0x001, and expect o_sum=0x008 and o_cnt=8.
REQ-036 The bench SHALL send 8 x 0xfff, then expect o_sum=0x7FF8 with no truncation.

Source files
------------

// File: rtl/operand_collector_8_pkg.sv
// Shared definitions for the operand collector: slot geometry, index/count
// widths and the collector FSM state encoding.
package operand_collector_8_pkg;

    // Default half-operand width; each operand is twice this wide.
    localparam int unsigned P_WIDTH_DEFAULT = 6;

    // Number of operand slots in one group and the widths that follow from it.
    localparam int unsigned SLOT_COUNT = 8;
    localparam int unsigned IDX_W      = 3;
    localparam int unsigned CNT_W      = 4;

    // Headroom bits needed to sum SLOT_COUNT operands without overflow.
    localparam int unsigned SUM_GROWTH = 3;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    // Full operand width for a given half-width parameter.
    function automatic int unsigned operand_width(input int unsigned half_width);
        return 2 * half_width;
    endfunction

endpackage

// File: rtl/operand_collector_8_adder.sv
// adder_8in: unsigned eight-input adder with full-precision result.
//
// Ports:
//   i_a .. i_h : 2*p_width-bit unsigned addends
//   o_sum      : 2*p_width+3-bit unsigned sum (cannot overflow)
//
// Purely combinational; the caller is responsible for feeding it from
// registers if a registered-source sum is required.
module adder_8in
    import operand_collector_8_pkg::*;
#(
    parameter int unsigned p_width = P_WIDTH_DEFAULT
) (
    input  logic [2*p_width-1:0] i_a,
    input  logic [2*p_width-1:0] i_b,
    input  logic [2*p_width-1:0] i_c,
    input  logic [2*p_width-1:0] i_d,
    input  logic [2*p_width-1:0] i_e,
    input  logic [2*p_width-1:0] i_f,
    input  logic [2*p_width-1:0] i_g,
    input  logic [2*p_width-1:0] i_h,
    output logic [2*p_width+2:0] o_sum
);

    localparam int unsigned OP_W = operand_width(p_width);

    // Balanced tree: each level gains exactly one bit of headroom.
    logic [OP_W:0]   sum_ab;
    logic [OP_W:0]   sum_cd;
    logic [OP_W:0]   sum_ef;
    logic [OP_W:0]   sum_gh;
    logic [OP_W+1:0] sum_abcd;
    logic [OP_W+1:0] sum_efgh;

    always_comb begin
        sum_ab   = {1'b0, i_a} + {1'b0, i_b};
        sum_cd   = {1'b0, i_c} + {1'b0, i_d};
        sum_ef   = {1'b0, i_e} + {1'b0, i_f};
        sum_gh   = {1'b0, i_g} + {1'b0, i_h};
        sum_abcd = {1'b0, sum_ab} + {1'b0, sum_cd};
        sum_efgh = {1'b0, sum_ef} + {1'b0, sum_gh};
        o_sum    = {1'b0, sum_abcd} + {1'b0, sum_efgh};
    end

endmodule

// File: rtl/operand_collector_8.sv
// operand_collector_8: gathers up to eight unsigned operands into a group
// and presents them, with their count and total, to a downstream consumer.
//
// Ports:
//   i_clk   : clock, all state on rising edge
//   i_rst   : synchronous active-high reset
//   i_valid : upstream operand valid
//   o_ready : operand accepted this cycle (COLLECT only)
//   i_data  : operand value, 2*p_width bits
//   i_last  : closes a short group (qualified by i_valid)
//   o_valid : collected group available (HOLD only)
//   i_ready : downstream consumes the group
//   o_ops   : eight slots packed, slot 0 at LSBs
//   o_cnt   : operands in the group, 1..8
//   o_sum   : full-precision sum of all slots
//
// A group closes on the eighth operand or on i_last; it is then held
// until consumed, with no operand accepted in the meantime.
module operand_collector_8
    import operand_collector_8_pkg::*;
#(
    parameter int unsigned p_width = P_WIDTH_DEFAULT
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [2*p_width-1:0] i_data,
    input  logic                 i_last,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [16*p_width-1:0] o_ops,
    output logic [CNT_W-1:0]     o_cnt,
    output logic [2*p_width+2:0] o_sum
);

    localparam int unsigned OP_W = operand_width(p_width);

    state_t              state;
    state_t              state_next;
    logic [IDX_W-1:0]    idx;
    logic [CNT_W-1:0]    cnt;
    logic [OP_W-1:0]     slots [SLOT_COUNT];
    logic                xfer;
    logic                close;
    logic                release_grp;

    assign xfer        = i_valid && o_ready;
    assign close       = xfer && ((idx == IDX_W'(SLOT_COUNT - 1)) || i_last);
    assign release_grp = (state == HOLD) && i_ready;

    always_comb begin
        state_next = state;
        o_ready    = 1'b0;
        o_valid    = 1'b0;
        case (state)
            COLLECT: begin
                // Gated by reset so nothing is accepted during the reset cycle.
                o_ready = !i_rst;
                if (close) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    state_next = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= COLLECT;
            idx   <= '0;
            cnt   <= '0;
            for (int unsigned i = 0; i < SLOT_COUNT; i++) begin
                slots[i] <= '0;
            end
        end else begin
            state <= state_next;
            if (release_grp) begin
                // Clearing here keeps unfilled slots of the next short group at zero.
                idx <= '0;
                cnt <= '0;
                for (int unsigned i = 0; i < SLOT_COUNT; i++) begin
                    slots[i] <= '0;
                end
            end else if (xfer) begin
                slots[idx] <= i_data;
                idx        <= idx + IDX_W'(1);
                if (close) begin
                    cnt <= CNT_W'(idx) + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        o_ops = '0;
        for (int unsigned i = 0; i < SLOT_COUNT; i++) begin
            o_ops[i*OP_W +: OP_W] = slots[i];
        end
    end

    assign o_cnt = cnt;

    adder_8in #(
        .p_width(p_width)
    ) u_adder (
        .i_a  (slots[0]),
        .i_b  (slots[1]),
        .i_c  (slots[2]),
        .i_d  (slots[3]),
        .i_e  (slots[4]),
        .i_f  (slots[5]),
        .i_g  (slots[6]),
        .i_h  (slots[7]),
        .o_sum(o_sum)
    );

endmodule

// File: tb/tb_operand_collector_8.sv
// Directed self-checking bench for operand_collector_8 (p_width = 6).
module tb_operand_collector_8;

    localparam int unsigned PW  = 6;
    localparam int unsigned OPW = 2 * PW;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              out_ready;
    logic [OPW-1:0]    in_data;
    logic              in_last;
    logic              out_valid;
    logic              in_ready;
    logic [16*PW-1:0]  ops;
    logic [3:0]        cnt;
    logic [OPW+2:0]    sum;

    int total = 0;
    int bad   = 0;

    operand_collector_8 #(
        .p_width(PW)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_valid(in_valid),
        .o_ready(out_ready),
        .i_data (in_data),
        .i_last (in_last),
        .o_valid(out_valid),
        .i_ready(in_ready),
        .o_ops  (ops),
        .o_cnt  (cnt),
        .o_sum  (sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [OPW-1:0] slot_of(input logic [16*PW-1:0] v, input int i);
        return v[i*OPW +: OPW];
    endfunction

    // Offers one operand and waits (bounded) for it to be accepted.
    task automatic send(input logic [OPW-1:0] d, input logic last);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!out_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (out_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_accept: o_ready=%b required=1 (timeout)", out_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic consume();
        @(negedge clk);
        in_ready = 1'b1;
        @(posedge clk);
        #1;
        in_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || ops !== '0) begin
            bad++;
            $display("FAIL consume_clear: o_valid=%b o_ops=%h required 0 and 0", out_valid, ops);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (out_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready: o_ready=%b required=0", out_ready);
        end
        total++;
        if (out_valid !== 1'b0 || cnt !== 4'd0 || sum !== '0 || ops !== '0) begin
            bad++;
            $display("FAIL reset_outputs: o_valid=%b o_cnt=%0d o_sum=%h o_ops=%h required all 0",
                     out_valid, cnt, sum, ops);
        end
        rst = 1'b0;
        #1;
        total++;
        if (out_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready: o_ready=%b required=1", out_ready);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 7; i++) send(12'h03f, 1'b0);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL full_early_valid: o_valid=%b required=0", out_valid);
        end
        send(12'h03f, 1'b0);
        total++;
        if (out_valid !== 1'b1 || sum !== 15'h1F8 || cnt !== 4'd8) begin
            bad++;
            $display("FAIL full_group: o_valid=%b o_sum=%h o_cnt=%0d required 1 1f8 8",
                     out_valid, sum, cnt);
        end
        consume();
    endtask

    task automatic test_mixed();
        send(12'h03f, 1'b0);
        for (int i = 0; i < 7; i++) send(12'h00f, 1'b0);
        total++;
        if (out_valid !== 1'b1 || sum !== 15'h0A8 || cnt !== 4'd8) begin
            bad++;
            $display("FAIL mixed_group: o_valid=%b o_sum=%h o_cnt=%0d required 1 0a8 8",
                     out_valid, sum, cnt);
        end
        total++;
        if (slot_of(ops, 0) !== 12'h03f || slot_of(ops, 7) !== 12'h00f) begin
            bad++;
            $display("FAIL mixed_slots: slot0=%h slot7=%h required 03f 00f",
                     slot_of(ops, 0), slot_of(ops, 7));
        end
        consume();
    endtask

    task automatic test_short();
        send(12'h001, 1'b0);
        send(12'h002, 1'b0);
        send(12'h003, 1'b1);
        total++;
        if (out_valid !== 1'b1 || cnt !== 4'd3 || sum !== 15'h006) begin
            bad++;
            $display("FAIL short_group: o_valid=%b o_cnt=%0d o_sum=%h required 1 3 006",
                     out_valid, cnt, sum);
        end
        total++;
        if (ops[16*PW-1:3*OPW] !== '0 || slot_of(ops, 2) !== 12'h003) begin
            bad++;
            $display("FAIL short_slots: slots7..3=%h slot2=%h required 0 003",
                     ops[16*PW-1:3*OPW], slot_of(ops, 2));
        end
        consume();
    endtask

    task automatic test_hold();
        for (int i = 0; i < 8; i++) send(12'h005, 1'b0);
        in_valid = 1'b1;
        in_data  = 12'h007;
        in_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            total++;
            if (out_ready !== 1'b0 || out_valid !== 1'b1 || sum !== 15'h028 ||
                cnt !== 4'd8 || slot_of(ops, 0) !== 12'h005) begin
                bad++;
                $display("FAIL hold_stable: cycle=%0d o_ready=%b o_valid=%b o_sum=%h o_cnt=%0d slot0=%h required 0 1 028 8 005",
                         c, out_ready, out_valid, sum, cnt, slot_of(ops, 0));
            end
        end
        @(negedge clk);
        in_ready = 1'b1;
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL hold_release_valid: o_valid=%b required=1", out_valid);
        end
        @(posedge clk);
        #1;
        in_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || out_ready !== 1'b1 || ops !== '0) begin
            bad++;
            $display("FAIL hold_no_consume: o_valid=%b o_ready=%b o_ops=%h required 0 1 0",
                     out_valid, out_ready, ops);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        total++;
        if (slot_of(ops, 0) !== 12'h007 || slot_of(ops, 1) !== 12'h000) begin
            bad++;
            $display("FAIL hold_first_after: slot0=%h slot1=%h required 007 000",
                     slot_of(ops, 0), slot_of(ops, 1));
        end
        pulse_reset();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) send(12'h0aa, 1'b0);
        total++;
        if (slot_of(ops, 3) !== 12'h0aa) begin
            bad++;
            $display("FAIL midreset_prefill: slot3=%h required 0aa", slot_of(ops, 3));
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (out_ready !== 1'b0) begin
            bad++;
            $display("FAIL midreset_ready: o_ready=%b required=0", out_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            total++;
            if (out_valid !== 1'b0 || ops !== '0 || cnt !== 4'd0) begin
                bad++;
                $display("FAIL midreset_discard: cycle=%0d o_valid=%b o_ops=%h o_cnt=%0d required 0 0 0",
                         c, out_valid, ops, cnt);
            end
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 8; i++) send(12'h001, 1'b0);
        total++;
        if (out_valid !== 1'b1 || sum !== 15'h008 || cnt !== 4'd8) begin
            bad++;
            $display("FAIL midreset_group: o_valid=%b o_sum=%h o_cnt=%0d required 1 008 8",
                     out_valid, sum, cnt);
        end
        consume();
    endtask

    task automatic test_max();
        for (int i = 0; i < 8; i++) send(12'hfff, 1'b0);
        total++;
        if (out_valid !== 1'b1 || sum !== 15'h7FF8 || cnt !== 4'd8) begin
            bad++;
            $display("FAIL max_group: o_valid=%b o_sum=%h o_cnt=%0d required 1 7ff8 8",
                     out_valid, sum, cnt);
        end
        consume();
    endtask

    // Continuous upstream and downstream: two groups take 18 cycles.
    task automatic test_back_to_back();
        int accepts = 0;
        int holds   = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_ready = 1'b1;
        in_data  = 12'h001;
        for (int c = 0; c < 18; c++) begin
            if (out_ready) accepts++;
            if (out_valid) holds++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_ready = 1'b0;
        total++;
        if (accepts != 16 || holds != 2) begin
            bad++;
            $display("FAIL back_to_back: accepts=%0d holds=%0d required 16 2", accepts, holds);
        end
        total++;
        if (out_valid !== 1'b0 || out_ready !== 1'b1 || ops !== '0) begin
            bad++;
            $display("FAIL back_to_back_end: o_valid=%b o_ready=%b o_ops=%h required 0 1 0",
                     out_valid, out_ready, ops);
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        in_ready = 1'b0;
        test_reset();
        test_full();
        test_mixed();
        test_short();
        test_hold();
        test_reset_mid();
        test_max();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
